// File: rtl/sample_burst_splitter.sv
// Circular-FIFO sample buffer that splits each wide sample into NUM_PORTS lanes and emits them in ACTIVE/IDLE bursts.
// Latency: 2 cycles write-to-out_valid; out_valid holds until out_ready, and in_ready (registered) drops when the FIFO is full.
module sample_burst_splitter #(
  parameter int NUM_PORTS = 2,
  parameter int LANE_W    = 32,
  parameter int DEPTH     = 4096,
  parameter int LEN_W     = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [NUM_PORTS*LANE_W-1:0]   in_data,
  output logic                          in_ready,
  output logic [NUM_PORTS*LANE_W-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sof,
  input  logic [LEN_W-1:0]              cfg_active_len,
  input  logic [LEN_W-1:0]              cfg_idle_len,
  input  logic                          clr_status,
  output logic                          overflow,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic                          active_phase
);
  localparam int DW = NUM_PORTS * LANE_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {ST_ACTIVE, ST_IDLE} state_t;

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level_nxt;
  logic             started, wr_en, ld, first;
  logic [LEN_W-1:0] act_len, idle_len, act_eff, cnt;
  state_t           state;

  assign wr_en        = in_valid && in_ready;
  assign ld           = active_phase && (fifo_level != '0) && (!out_valid || out_ready);
  assign act_eff      = (act_len == '0) ? LEN_W'(1) : act_len;
  assign active_phase = (state == ST_ACTIVE);

  always_comb begin
    level_nxt = fifo_level;
    if (wr_en && !ld)
      level_nxt = fifo_level + (AW+1)'(1);
    else if (!wr_en && ld)
      level_nxt = fifo_level - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_data;
  end

  // in_ready looks at the next-state level so an accepted write always has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      in_ready   <= 1'b0;
      overflow   <= 1'b0;
      started    <= 1'b0;
    end else begin
      started    <= 1'b1;
      fifo_level <= level_nxt;
      in_ready   <= (level_nxt != FULL);
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (ld)
        rd_ptr <= rd_ptr + AW'(1);
      if (in_valid && !in_ready)
        overflow <= 1'b1;
      else if (clr_status)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACTIVE;
      cnt       <= '0;
      act_len   <= '0;
      idle_len  <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
    end else begin
      if (!started)
        act_len <= cfg_active_len;

      if (ld) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
        out_sof   <= first;
        first     <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
      end

      case (state)
        ST_ACTIVE: begin
          if (ld) begin
            if (cnt + LEN_W'(1) == act_eff) begin
              cnt   <= '0;
              first <= 1'b1;
              // A zero idle length chains straight into the next burst.
              if (cfg_idle_len == '0) begin
                act_len <= cfg_active_len;
              end else begin
                state    <= ST_IDLE;
                idle_len <= cfg_idle_len;
              end
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        ST_IDLE: begin
          if (cnt == idle_len - LEN_W'(1)) begin
            state   <= ST_ACTIVE;
            cnt     <= '0;
            act_len <= cfg_active_len;
          end else begin
            cnt <= cnt + LEN_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sample_burst_splitter.sv
// Bench for sample_burst_splitter (2 lanes x 32 bits, 4-entry FIFO): vector table plus in-order scoreboard.
module tb_sample_burst_splitter;
  localparam int NUM_PORTS = 2;
  localparam int LANE_W    = 32;
  localparam int DEPTH     = 4;
  localparam int LEN_W     = 20;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_sof;
  logic [63:0] in_data, out_data;
  logic [19:0] cfg_active_len, cfg_idle_len;
  logic        clr_status, overflow, active_phase;
  logic [2:0]  fifo_level;

  sample_burst_splitter #(.NUM_PORTS(NUM_PORTS), .LANE_W(LANE_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .cfg_active_len(cfg_active_len), .cfg_idle_len(cfg_idle_len), .clr_status(clr_status),
    .overflow(overflow), .fifo_level(fifo_level), .active_phase(active_phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        ordy;
    logic        clr;
    logic        acc;
    logic        e_ir;
    logic        e_ovf;
    logic [2:0]  e_lvl;
    logic        e_ov;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb[$];
  int          out_idx;
  int          eff_act;
  logic        samp_ov;
  int          src_left;
  logic [63:0] src_next;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Output handshakes are observed on the falling edge, then the clock advances past the next rise.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_output: got %h expected none", out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_out_data", out_data, e);
        chk("sb_out_sof", 64'(out_sof), 64'((out_idx % eff_act) == 0));
        out_idx++;
      end
    end
    chk("level_bound", 64'(int'(fifo_level) <= DEPTH), 64'h1);
    samp_ov = out_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src();
    if (src_left > 0 && in_ready) begin
      in_valid = 1'b1;
      in_data  = src_next;
      sb.push_back(src_next);
      src_next = src_next + 64'd1;
      src_left--;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    drive_src();
    tick();
  endtask

  task automatic do_reset(input int act, input int idle);
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b0;
    clr_status     = 1'b0;
    cfg_active_len = 20'(act);
    cfg_idle_len   = 20'(idle);
    eff_act        = (act == 0) ? 1 : act;
    sb.delete();
    out_idx  = 0;
    src_left = 0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_sof", 64'(out_sof), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_fifo_level", 64'(fifo_level), 64'h0);
    chk("rst_active_phase", 64'(active_phase), 64'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);
  endtask

  task automatic drain();
    src_left  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() > 0; i++) cycle();
    chk("drain_sb_empty", 64'(sb.size()), 64'h0);
    cycle();
    cycle();
    chk("drain_level_zero", 64'(fifo_level), 64'h0);
  endtask

  task automatic run_stream(input int n, input logic [63:0] base, input int act, input int idle, input bit rnd);
    do_reset(act, idle);
    src_next = base;
    src_left = n;
    for (int i = 0; i < 400 && (src_left > 0 || sb.size() > 0); i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
    end
    drain();
    chk("stream_out_count", 64'(out_idx), 64'(n));
  endtask

  initial begin
    vec_t tbl[11];
    bit   found;

    // Overflow/backpressure vectors, out_ready low: the first sample moves into the output
    // register, four more fill the FIFO, later offers are dropped.
    tbl[0]  = '{1'b1, 64'hC0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[1]  = '{1'b1, 64'hC1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1};
    tbl[2]  = '{1'b1, 64'hC2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1};
    tbl[3]  = '{1'b1, 64'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1};
    tbl[4]  = '{1'b1, 64'hC4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1};
    tbl[5]  = '{1'b1, 64'hC5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1};
    tbl[6]  = '{1'b1, 64'hC6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1};
    tbl[7]  = '{1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1};
    tbl[8]  = '{1'b1, 64'hC7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1};
    tbl[9]  = '{1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1};
    tbl[10] = '{1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1};

    samp_ov = 1'b0;
    src_next = '0;

    // First sample: lane split, sof, and two-cycle latency.
    do_reset(4, 3);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hAAAA_BBBB_1111_2222;
    sb.push_back(64'hAAAA_BBBB_1111_2222);
    tick();
    in_valid = 1'b0;
    chk("A_valid_n1", 64'(out_valid), 64'h0);
    tick();
    chk("A_valid_n2", 64'(out_valid), 64'h1);
    chk("A_lane1", 64'(out_data[63:32]), 64'hAAAABBBB);
    chk("A_lane0", 64'(out_data[31:0]), 64'h11112222);
    chk("A_sof", 64'(out_sof), 64'h1);
    drain();

    // Bursts of 4 valid cycles separated by 3 idle cycles.
    do_reset(4, 3);
    out_ready = 1'b1;
    src_next  = 64'h1000;
    src_left  = 60;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = samp_ov;
    end
    chk("B_first_valid_seen", 64'(found), 64'h1);
    for (int i = 1; i < 28; i++) begin
      cycle();
      chk("B_burst_pattern", 64'(samp_ov), 64'((i % 7) < 4));
    end
    drain();

    // Backpressure, overflow and clr_status priority.
    do_reset(100, 0);
    for (int i = 0; i < 11; i++) begin
      in_valid   = tbl[i].v;
      in_data    = tbl[i].d;
      out_ready  = tbl[i].ordy;
      clr_status = tbl[i].clr;
      if (tbl[i].acc) sb.push_back(tbl[i].d);
      tick();
      chk("C_in_ready", 64'(in_ready), 64'(tbl[i].e_ir));
      chk("C_overflow", 64'(overflow), 64'(tbl[i].e_ovf));
      chk("C_fifo_level", 64'(fifo_level), 64'(tbl[i].e_lvl));
      chk("C_out_valid", 64'(out_valid), 64'(tbl[i].e_ov));
    end
    in_valid   = 1'b0;
    clr_status = 1'b0;
    drain();
    chk("C_in_ready_after_drain", 64'(in_ready), 64'h1);

    // Last sample of a burst stalled through the whole IDLE phase.
    do_reset(2, 3);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hD0;
    sb.push_back(64'hD0);
    tick();
    in_data = 64'hD1;
    sb.push_back(64'hD1);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("D_enter_idle", 64'(active_phase), 64'h0);
    chk("D_hold_data0", out_data, 64'hD1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("D_hold_valid", 64'(out_valid), 64'h1);
      chk("D_hold_data", out_data, 64'hD1);
    end
    chk("D_back_active", 64'(active_phase), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("D_no_duplicate", 64'(out_valid), 64'h0);
    drain();

    // Pointer wrap with random output backpressure, then zero lengths.
    run_stream(3 * DEPTH, 64'h5000, 3, 1, 1'b1);
    run_stream(6, 64'h7000, 0, 0, 1'b0);

    // Reset in the middle of a burst with three samples queued.
    do_reset(100, 0);
    out_ready = 1'b0;
    src_next  = 64'h9000;
    src_left  = 4;
    for (int i = 0; i < 4; i++) cycle();
    in_valid = 1'b0;
    chk("G_level_before_reset", 64'(fifo_level), 64'h3);
    chk("G_valid_before_reset", 64'(out_valid), 64'h1);
    #2;
    do_reset(100, 0);
    out_ready = 1'b1;
    src_next  = 64'hBEEF;
    src_left  = 1;
    for (int i = 0; i < 20 && (src_left > 0 || sb.size() > 0); i++) cycle();
    chk("G_sb_empty", 64'(sb.size()), 64'h0);
    chk("G_out_count", 64'(out_idx), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
